lsu_mem_initiator: RTL and testbench

- Multi-cycle load/store initiator between the core datapath and the word-wide DataMemory.
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake.
- Drives full-word-only memory accesses; subword stores use read-modify-write.
- Loads are sign- or zero-extended per funct3, and misaligned or illegal requests are rejected without touching memory.

---
 rtl/lsu_mem_initiator.sv | 192 +++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: byte-addressed RV32 load/store front end for a word-only data memory.
// Subword stores are read-modify-write; illegal or misaligned requests answer with an error and never touch memory.
module lsu_mem_initiator #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [2:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready. req_ready is
    // high only in IDLE; completion is a single resp_valid pulse that cannot be back-pressured.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic              ready_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-3:0] addr_q;
    logic [WIDTH-1:0]  mem_wdata_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_illegal;
    logic              req_misaligned;
    logic              req_err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [WIDTH-1:0]  load_ext;
    logic [WIDTH-1:0]  merged;

    // Request decode, evaluated on the live inputs so the accept edge can branch immediately.
    always_comb begin
        req_illegal = 1'b1;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
                default:                req_illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
                default:                                req_illegal = 1'b1;
            endcase
        end
        req_misaligned = 1'b0;
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_misaligned = 1'b1;
        end
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) begin
            req_misaligned = 1'b1;
        end
        req_err = req_illegal || req_misaligned;
    end

    // Lane selection and extension for loads, lane replacement for subword stores.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_ext = mem_rdata;
        endcase

        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (off_q)
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                2'd3:    merged[31:24] = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (funct3_q[1:0] == 2'b01) begin
            if (off_q[1]) begin
                merged[31:16] = wdata_q;
            end else begin
                merged[15:0] = wdata_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (req_we && req_funct3 == 3'b010) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_MERGE;
            S_MERGE: state_d = we_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ready_q is registered from the next state so it stays low through reset and only
    // rises on the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                off_q    <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
                addr_q   <= req_addr[ADDR_W-1:2];
                rdata_q  <= '0;
                err_q    <= req_err;
                if (req_we && !req_err && req_funct3 == 3'b010) begin
                    mem_wdata_q <= req_wdata;
                end
            end
            if (state_q == S_MERGE) begin
                if (we_q) begin
                    mem_wdata_q <= merged;
                end else begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign mem_rd     = (state_q == S_READ);
    assign mem_wr     = (state_q == S_WRITE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed and random requests checked against a byte-level
// reference model of RV32 load/store semantics and a word-wide memory.
module tb_lsu_mem_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_rdata;
    logic [31:0] last_wdata;

    lsu_mem_initiator #(.ADDR_W(8), .WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock and a hard time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected $finish before time limit");
        $fatal(1);
    end

    // Word-wide memory with registered read data.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic on the architectural rules, plus expected cycle offsets.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                                  output logic [31:0] wword, output int rd_c, output int wr_c,
                                  output int resp_c);
        int nbytes;
        int off;
        logic legal;
        logic [63:0] v;
        logic [63:0] mask;
        logic [31:0] word;
        nbytes = 1 << f3[1:0];
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err    = !legal || ((int'(addr) % nbytes) != 0);
        off    = int'(addr) % 4;
        word   = ref_mem[int'(addr) / 4];
        rdata  = 32'd0;
        wword  = word;
        rd_c   = 0;
        wr_c   = 0;
        resp_c = 1;
        if (err) return;
        if (!we) begin
            mask = (64'd1 << (nbytes * 8)) - 64'd1;
            v = ({32'd0, word} >> (off * 8)) & mask;
            if (!f3[2] && nbytes < 4 && v[nbytes*8-1]) v = v | ~mask;
            rdata  = v[31:0];
            rd_c   = 1;
            resp_c = 3;
        end else begin
            for (int i = 0; i < nbytes; i++) wword[(off+i)*8 +: 8] = wd[i*8 +: 8];
            if (nbytes == 4) begin
                wr_c   = 1;
                resp_c = 2;
            end else begin
                rd_c   = 1;
                wr_c   = 3;
                resp_c = 4;
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_dbg_state"}, dbg_state, 0);
    endtask

    // Driver + monitor for one request; cycle k means k cycles after the accept edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                           input logic [31:0] wd, input string tag);
        logic e_err;
        logic [31:0] e_rdata, e_wword, got_rdata, got_wdata;
        logic got_err, ready_after, hold_ok;
        int e_rd, e_wr, e_resp, w;
        int rd_at, wr_at, resp_at, nrd, nwr, nresp, both, bad_ready, bad_addr;
        model(we, f3, addr, wd, e_err, e_rdata, e_wword, e_rd, e_wr, e_resp);
        exp_q.push_back(e_rdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready_wait"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = 8'($urandom); req_wdata = $urandom;
        rd_at = 0; wr_at = 0; resp_at = 0; nrd = 0; nwr = 0; nresp = 0;
        both = 0; bad_ready = 0; bad_addr = 0; ready_after = 0; hold_ok = 0;
        got_rdata = '0; got_wdata = '0; got_err = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_rd) begin nrd++; rd_at = k; end
            if (mem_wr) begin nwr++; wr_at = k; got_wdata = mem_wdata; end
            if (mem_rd && mem_wr) both++;
            if (resp_valid) begin
                nresp++; resp_at = k; got_rdata = resp_rdata; got_err = resp_err;
            end
            if (resp_at == 0 || k == resp_at) begin
                if (req_ready) bad_ready++;
                if (mem_addr !== addr[7:2]) bad_addr++;
            end
            if (resp_at != 0 && k == resp_at + 1) begin
                ready_after = req_ready;
                hold_ok = (resp_rdata === got_rdata) && (resp_err === got_err);
            end
        end
        chk({tag, "_resp_cycle"}, resp_at, e_resp);
        chk({tag, "_rd_cycle"}, rd_at, e_rd);
        chk({tag, "_wr_cycle"}, wr_at, e_wr);
        chk({tag, "_rd_pulses"}, nrd, (e_rd != 0) ? 1 : 0);
        chk({tag, "_wr_pulses"}, nwr, (e_wr != 0) ? 1 : 0);
        chk({tag, "_resp_pulses"}, nresp, 1);
        chk({tag, "_rd_wr_overlap"}, both, 0);
        chk({tag, "_ready_busy"}, bad_ready, 0);
        chk({tag, "_addr_stable"}, bad_addr, 0);
        chk({tag, "_ready_after"}, ready_after, 1);
        chk({tag, "_resp_hold"}, hold_ok, 1);
        chk({tag, "_err"}, got_err, e_err);
        chk({tag, "_rdata"}, got_rdata, exp_q.pop_front());
        if (we && !e_err) begin
            chk({tag, "_wdata"}, got_wdata, e_wword);
            ref_mem[addr[7:2]] = e_wword;
            chk({tag, "_mem_word"}, mem[addr[7:2]], ref_mem[addr[7:2]]);
        end
        last_rdata = got_rdata;
        last_wdata = got_wdata;
    endtask

    initial begin
        logic [2:0] f3;
        logic [7:0] a;
        logic       we;
        logic       e_err;
        logic [31:0] e0, e1, e_ww, d1, d2, wd;
        int c_rd, c_wr, c_resp, r1, r2, a2, bad, w;
        logic wr_seen;

        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 8'h00; req_wdata = 32'h0; mem_rdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h8001F0A5; ref_mem[0] = 32'h8001F0A5;
        mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;

        // Power-on reset: outputs must be zero while rst_n is low.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("por_ready_rise", req_ready, 1);

        // Directed loads from word 0 = 0x8001F0A5.
        run_req(0, 3'b000, 8'd0, 32'h0, "lb0");
        chk("lb0_const", last_rdata, 32'hFFFFFFA5);
        run_req(0, 3'b100, 8'd1, 32'h0, "lbu1");
        chk("lbu1_const", last_rdata, 32'h000000F0);
        run_req(0, 3'b001, 8'd2, 32'h0, "lh2");
        chk("lh2_const", last_rdata, 32'hFFFF8001);
        run_req(0, 3'b101, 8'd2, 32'h0, "lhu2");
        chk("lhu2_const", last_rdata, 32'h00008001);

        // Subword store RMW and word store.
        run_req(1, 3'b000, 8'd5, 32'hFFFFFF5A, "sb5");
        chk("sb5_const", last_wdata, 32'h11225A44);
        run_req(0, 3'b010, 8'd4, 32'h0, "lw4");
        chk("lw4_const", last_rdata, 32'h11225A44);
        run_req(1, 3'b010, 8'd8, 32'hA5A5A5A5, "sw8");
        run_req(0, 3'b010, 8'd8, 32'h0, "lw8");
        chk("lw8_const", last_rdata, 32'hA5A5A5A5);

        // Error requests: misaligned and illegal funct3.
        run_req(0, 3'b010, 8'd6, 32'h0, "lw6_mis");
        run_req(1, 3'b001, 8'd3, 32'h1234, "sh3_mis");
        run_req(0, 3'b011, 8'd0, 32'h0, "ld_f3_011");
        run_req(1, 3'b100, 8'd0, 32'hDEAD, "st_f3_100");

        // Back-to-back: req_valid held high across two LW requests.
        model(0, 3'b010, 8'd4, 32'h0, e_err, e0, e_ww, c_rd, c_wr, c_resp);
        model(0, 3'b010, 8'd8, 32'h0, e_err, e1, e_ww, c_rd, c_wr, c_resp);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'd4;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_addr = 8'd8;
        r1 = 0; r2 = 0; a2 = 0; bad = 0; d1 = '0; d2 = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (r1 == 0) begin r1 = k; d1 = resp_rdata; end
                else begin r2 = k; d2 = resp_rdata; end
            end
            if (req_ready && a2 == 0) begin
                a2 = k;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end else if (req_ready && r2 == 0) begin
                bad++;
            end
        end
        chk("b2b_resp1_cycle", r1, 3);
        chk("b2b_accept2_cycle", a2, 4);
        chk("b2b_resp2_cycle", r2, 7);
        chk("b2b_ready_busy", bad, 0);
        chk("b2b_rdata1", d1, e0);
        chk("b2b_rdata2", d2, e1);

        // Reset in the MERGE cycle of an SH: the write must never happen.
        wd = ~ref_mem[3];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 8'd14; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_phase", mem_rd, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        wr_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr) wr_seen = 1'b1;
        end
        chk("rst_mid_no_wr", wr_seen, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_mem_unchanged", mem[3], ref_mem[3]);
        run_req(0, 3'b010, 8'd12, 32'h0, "post_rst_lw");

        // Random mix, weighted towards legal aligned requests.
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            run_req(we, f3, a, $urandom, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
